branch_resolve_unit: RTL and testbench

//  Execute-side counterpart of the fetch-stage direction predictor (PHT).
//  - Carries each fetched instruction's prediction (2-bit counter, predicted target) through the F->D->E stages.
//  - Resolves it in E against the actual outcome; flags mispredicts; drives the front-end redirect and the D/E flushes.
//  - Issues the PHT training strobe and keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Carries fetch-time direction/target predictions through D and
//               E, resolves them against the real outcome in E, drives the
//               redirect/flush controls, trains the PHT and keeps statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_F,
  input  logic [XLEN-1:0]  pc_F,
  input  logic [1:0]       predict_F,
  input  logic [XLEN-1:0]  tgt_pred_F,
  input  logic             stall_D,
  input  logic             flush_D_ext,
  input  logic             branch_E,
  input  logic             jump_E,
  input  logic             take_E,
  input  logic [XLEN-1:0]  tgt_E,
  output logic             mispredict_E,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_D,
  output logic             flush_E,
  output logic             upd_valid,
  output logic             upd_jump,
  output logic             upd_take,
  output logic [IDX_W-1:0] upd_idx,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);

  // D stage
  logic             r_valid_D;
  logic [XLEN-1:0]  r_pc_D;
  logic [1:0]       r_pred_D;
  logic [XLEN-1:0]  r_tgt_D;
  // E stage
  logic             r_valid_E;
  logic [XLEN-1:0]  r_pc_E;
  logic [1:0]       r_pred_E;
  logic [XLEN-1:0]  r_tgt_E;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic             w_res;
  logic             w_act_take;
  logic             w_ptk;
  logic             w_tgt_miss;
  logic             w_mispredict;
  logic             w_upd_valid;
  logic [XLEN-1:0]  w_seq_pc;
  logic             w_unused;

  // Only the direction bit of the counter matters for resolution.
  assign w_unused = r_pred_E[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_D <= 1'b0;
      r_pc_D    <= '0;
      r_pred_D  <= '0;
      r_tgt_D   <= '0;
      r_valid_E <= 1'b0;
      r_pc_E    <= '0;
      r_pred_E  <= '0;
      r_tgt_E   <= '0;
    end else if (w_mispredict) begin
      // A mispredict kills everything younger, even under a stall.
      r_valid_D <= 1'b0;
      r_valid_E <= 1'b0;
    end else if (!stall_D) begin
      r_valid_D <= valid_F & ~flush_D_ext;
      r_pc_D    <= pc_F;
      r_pred_D  <= predict_F;
      r_tgt_D   <= tgt_pred_F;
      r_valid_E <= r_valid_D;
      r_pc_E    <= r_pc_D;
      r_pred_E  <= r_pred_D;
      r_tgt_E   <= r_tgt_D;
    end
  end

  // take_E only has meaning for conditional branches; a jump is always taken.
  assign w_res        = r_valid_E & (branch_E | jump_E);
  assign w_act_take   = jump_E | (branch_E & take_E);
  assign w_ptk        = r_pred_E[1];
  assign w_tgt_miss   = (r_tgt_E != tgt_E);
  assign w_mispredict = w_res & ((w_ptk != w_act_take) |
                                 (w_ptk & w_act_take & w_tgt_miss));
  assign w_seq_pc     = r_pc_E + c_PC_STEP;
  assign w_upd_valid  = w_res & ~stall_D;

  assign mispredict_E = w_mispredict;
  assign redirect_pc  = w_res ? (w_act_take ? tgt_E : w_seq_pc) : '0;
  assign flush_D      = w_mispredict | flush_D_ext;
  assign flush_E      = w_mispredict;
  assign upd_valid    = w_upd_valid;
  assign upd_jump     = w_res & jump_E;
  assign upd_take     = w_res & w_act_take;
  assign upd_idx      = w_res ? r_pc_E[IDX_W+1:2] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_upd_valid) begin
      if (r_br_cnt != c_CNT_MAX) begin
        r_br_cnt <= r_br_cnt + 1'b1;
      end
      if (w_mispredict && (r_mp_cnt != c_CNT_MAX)) begin
        r_mp_cnt <= r_mp_cnt + 1'b1;
      end
    end
  end

  assign br_cnt = r_br_cnt;
  assign mp_cnt = r_mp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// Directed self-checking bench for branch_resolve_unit; a second instance with
// 2-bit counters exposes statistics saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_F;
  logic [31:0] pc_F;
  logic [1:0]  predict_F;
  logic [31:0] tgt_pred_F;
  logic        stall_D;
  logic        flush_D_ext;
  logic        branch_E;
  logic        jump_E;
  logic        take_E;
  logic [31:0] tgt_E;

  logic        w_mispredict_E;
  logic [31:0] w_redirect_pc;
  logic        w_flush_D;
  logic        w_flush_E;
  logic        w_upd_valid;
  logic        w_upd_jump;
  logic        w_upd_take;
  logic [3:0]  w_upd_idx;
  logic [15:0] w_br_cnt;
  logic [15:0] w_mp_cnt;

  logic        s_mispredict_E;
  logic [31:0] s_redirect_pc;
  logic        s_flush_D;
  logic        s_flush_E;
  logic        s_upd_valid;
  logic        s_upd_jump;
  logic        s_upd_take;
  logic [3:0]  s_upd_idx;
  logic [1:0]  s_br_cnt;
  logic [1:0]  s_mp_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_unit #(.XLEN(32), .IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_F(valid_F), .pc_F(pc_F),
    .predict_F(predict_F), .tgt_pred_F(tgt_pred_F), .stall_D(stall_D),
    .flush_D_ext(flush_D_ext), .branch_E(branch_E), .jump_E(jump_E),
    .take_E(take_E), .tgt_E(tgt_E), .mispredict_E(w_mispredict_E),
    .redirect_pc(w_redirect_pc), .flush_D(w_flush_D), .flush_E(w_flush_E),
    .upd_valid(w_upd_valid), .upd_jump(w_upd_jump), .upd_take(w_upd_take),
    .upd_idx(w_upd_idx), .br_cnt(w_br_cnt), .mp_cnt(w_mp_cnt)
  );

  branch_resolve_unit #(.XLEN(32), .IDX_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_F(valid_F), .pc_F(pc_F),
    .predict_F(predict_F), .tgt_pred_F(tgt_pred_F), .stall_D(stall_D),
    .flush_D_ext(flush_D_ext), .branch_E(branch_E), .jump_E(jump_E),
    .take_E(take_E), .tgt_E(tgt_E), .mispredict_E(s_mispredict_E),
    .redirect_pc(s_redirect_pc), .flush_D(s_flush_D), .flush_E(s_flush_E),
    .upd_valid(s_upd_valid), .upd_jump(s_upd_jump), .upd_take(s_upd_take),
    .upd_idx(s_upd_idx), .br_cnt(s_br_cnt), .mp_cnt(s_mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    branch_E = 1'b0;
    jump_E   = 1'b0;
    take_E   = 1'b0;
    tgt_E    = '0;
  endtask

  // Push one instruction through F and D so it sits in E on return.
  task automatic issue(input logic [31:0] pc, input logic [1:0] pred, input logic [31:0] tgt);
    clear_e();
    valid_F    = 1'b1;
    pc_F       = pc;
    predict_F  = pred;
    tgt_pred_F = tgt;
    tick();
    valid_F    = 1'b0;
    pc_F       = '0;
    predict_F  = '0;
    tgt_pred_F = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; valid_F = 1'b0; pc_F = '0; predict_F = '0; tgt_pred_F = '0;
    stall_D = 1'b0; flush_D_ext = 1'b0;
    clear_e();
    repeat (2) tick();
    check_val("rst_mispredict", 64'(w_mispredict_E), 64'd0);
    check_val("rst_redirect", 64'(w_redirect_pc), 64'd0);
    check_val("rst_upd_valid", 64'(w_upd_valid), 64'd0);
    check_val("rst_br_cnt", 64'(w_br_cnt), 64'd0);
    check_val("rst_mp_cnt", 64'(w_mp_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // flush_D follows the external bubble request combinationally
    flush_D_ext = 1'b1; #1;
    check_val("ext_flush_D", 64'(w_flush_D), 64'd1);
    check_val("ext_flush_E", 64'(w_flush_E), 64'd0);
    flush_D_ext = 1'b0;

    // Non-branch in E: take_E must be ignored
    issue(32'h0000_0008, 2'b00, 32'h0);
    take_E = 1'b1; #1;
    check_val("nb_upd_valid", 64'(w_upd_valid), 64'd0);
    check_val("nb_mispredict", 64'(w_mispredict_E), 64'd0);
    tick();

    // T1: strongly taken, taken, target matches
    issue(32'h0000_0010, 2'b11, 32'h0000_0050);
    branch_E = 1'b1; take_E = 1'b1; tgt_E = 32'h0000_0050; #1;
    check_val("t1_mispredict", 64'(w_mispredict_E), 64'd0);
    check_val("t1_upd_valid", 64'(w_upd_valid), 64'd1);
    check_val("t1_upd_take", 64'(w_upd_take), 64'd1);
    check_val("t1_upd_idx", 64'(w_upd_idx), 64'h4);
    tick(); clear_e(); #1;
    check_val("t1_br_cnt", 64'(w_br_cnt), 64'd1);
    check_val("t1_mp_cnt", 64'(w_mp_cnt), 64'd0);

    // T2: predicted not taken, actually taken; younger F instr must not enter D
    issue(32'h0000_0040, 2'b01, 32'h0);
    branch_E = 1'b1; take_E = 1'b1; tgt_E = 32'h0000_0080;
    valid_F = 1'b1; pc_F = 32'h0000_0044; #1;
    check_val("t2_mispredict", 64'(w_mispredict_E), 64'd1);
    check_val("t2_redirect", 64'(w_redirect_pc), 64'h80);
    check_val("t2_flush_D", 64'(w_flush_D), 64'd1);
    check_val("t2_flush_E", 64'(w_flush_E), 64'd1);
    tick(); clear_e(); valid_F = 1'b0; #1;
    check_val("t2_valid_D", 64'(dut.r_valid_D), 64'd0);
    check_val("t2_valid_E", 64'(dut.r_valid_E), 64'd0);
    check_val("t2_br_cnt", 64'(w_br_cnt), 64'd2);
    check_val("t2_mp_cnt", 64'(w_mp_cnt), 64'd1);

    // T3: predicted taken, not taken -> fall through
    issue(32'h0000_0100, 2'b10, 32'h0000_0180);
    branch_E = 1'b1; take_E = 1'b0; tgt_E = 32'h0000_0180; #1;
    check_val("t3_mispredict", 64'(w_mispredict_E), 64'd1);
    check_val("t3_redirect", 64'(w_redirect_pc), 64'h104);
    check_val("t3_upd_take", 64'(w_upd_take), 64'd0);
    check_val("t3_upd_idx", 64'(w_upd_idx), 64'h0);
    tick(); clear_e(); #1;
    check_val("t3_br_cnt", 64'(w_br_cnt), 64'd3);
    check_val("t3_sat_br", 64'(s_br_cnt), 64'd3);

    // T4: jalr with wrong predicted target
    issue(32'h0000_0020, 2'b11, 32'h0000_0200);
    jump_E = 1'b1; tgt_E = 32'h0000_0300; #1;
    check_val("t4_mispredict", 64'(w_mispredict_E), 64'd1);
    check_val("t4_redirect", 64'(w_redirect_pc), 64'h300);
    check_val("t4_upd_jump", 64'(w_upd_jump), 64'd1);
    check_val("t4_upd_take", 64'(w_upd_take), 64'd1);
    tick(); clear_e(); #1;
    check_val("t4_br_cnt", 64'(w_br_cnt), 64'd4);
    check_val("t4_mp_cnt", 64'(w_mp_cnt), 64'd3);
    check_val("t4_sat_br_hold", 64'(s_br_cnt), 64'd3);

    // Branch and jump both high, take_E low: jump wins
    issue(32'h0000_0030, 2'b11, 32'h0000_0090);
    branch_E = 1'b1; jump_E = 1'b1; take_E = 1'b0; tgt_E = 32'h0000_0090; #1;
    check_val("bj_mispredict", 64'(w_mispredict_E), 64'd0);
    check_val("bj_upd_jump", 64'(w_upd_jump), 64'd1);
    check_val("bj_upd_take", 64'(w_upd_take), 64'd1);
    tick(); clear_e(); #1;
    check_val("bj_br_cnt", 64'(w_br_cnt), 64'd5);

    // T5: stall for 3 cycles with a correctly predicted branch in E
    issue(32'h0000_0024, 2'b11, 32'h0000_0070);
    branch_E = 1'b1; take_E = 1'b1; tgt_E = 32'h0000_0070;
    stall_D = 1'b1; valid_F = 1'b1; pc_F = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t5_stall_upd_valid", 64'(w_upd_valid), 64'd0);
      tick();
      check_val("t5_stall_pc_E", 64'(dut.r_pc_E), 64'h24);
      check_val("t5_stall_valid_D", 64'(dut.r_valid_D), 64'd0);
    end
    check_val("t5_stall_br_cnt", 64'(w_br_cnt), 64'd5);
    stall_D = 1'b0; valid_F = 1'b0; pc_F = '0; #1;
    check_val("t5_release_upd_valid", 64'(w_upd_valid), 64'd1);
    tick(); clear_e(); #1;
    check_val("t5_br_cnt", 64'(w_br_cnt), 64'd6);
    check_val("t5_mp_cnt", 64'(w_mp_cnt), 64'd3);

    // T6: fourth mispredict; 2-bit mispredict counter must hold at 3
    issue(32'h0000_0050, 2'b00, 32'h0);
    branch_E = 1'b1; take_E = 1'b1; tgt_E = 32'h0000_0060; #1;
    check_val("t6_redirect", 64'(w_redirect_pc), 64'h60);
    tick(); clear_e(); #1;
    check_val("t6_mp_cnt", 64'(w_mp_cnt), 64'd4);
    check_val("t6_sat_mp_hold", 64'(s_mp_cnt), 64'd3);
    check_val("t6_sat_br_hold", 64'(s_br_cnt), 64'd3);

    // Async reset mid-cycle with a mispredicting branch in E
    issue(32'h0000_0060, 2'b01, 32'h0);
    branch_E = 1'b1; take_E = 1'b1; tgt_E = 32'h0000_0064; #1;
    check_val("ar_pre_mispredict", 64'(w_mispredict_E), 64'd1);
    rst_n = 1'b0; #1;
    check_val("ar_mispredict", 64'(w_mispredict_E), 64'd0);
    check_val("ar_upd_valid", 64'(w_upd_valid), 64'd0);
    check_val("ar_valid_E", 64'(dut.r_valid_E), 64'd0);
    check_val("ar_br_cnt", 64'(w_br_cnt), 64'd0);
    check_val("ar_mp_cnt", 64'(w_mp_cnt), 64'd0);
    tick();
    check_val("ar_hold_br_cnt", 64'(w_br_cnt), 64'd0);
    clear_e();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
